mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Multi-cycle access controller between the pipeline's MEM stage and the data memory. It accepts one load or store per request from the EXE/MEM register and stalls the pipeline via `freeze` while the request is serviced. It drives the data memory with a fixed number of wait cycles and returns registered read data. Malformed requests (unaligned, out of range, or read and write together) are rejected with a fault and never touch the memory.

## Interface
- `WAIT_CYCLES`, default 3: memory access cycles per request; legal values are 1..15.
- `BASE_ADDR`, default 1024: byte address of the first data-memory word.
- `DEPTH_WORDS`, default 2048: data-memory depth in 32-bit words.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_r_en` in 1: load request from the MEM stage.
- `req_w_en` in 1: store request from the MEM stage.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data.
- `freeze` out 1: pipeline stall, combinational.
- `ready` out 1: one-cycle completion pulse.
- `fault` out 1: valid only with `ready`; high means the request was rejected.
- `rdata` out 32: last completed load data.
- `mem_r_en` out 1: data-memory read enable.
- `mem_w_en` out 1: data-memory write enable.
- `mem_address` out 32: byte address to the memory, passed unconverted.
- `mem_data_in` out 32: write data to the memory.
- `mem_data_out` in 32: combinational read data from the memory.

## Operation
- States are IDLE, ACCESS, and DONE.
- Address validity requires all of:
  - `req_addr[1:0]==0`
  - `BASE_ADDR <= req_addr`
  - `req_addr < BASE_ADDR + 4*DEPTH_WORDS`
  - The compare is done in 33 bits so there is no wrap-around.
- IDLE behaviour:
  - A request is `req_r_en|req_w_en`.
  - Valid request with exactly one enable: latch addr, wdata and type; load counter with `WAIT_CYCLES-1`; go to ACCESS.
  - Invalid address, or both enables high: latch fault; go to DONE with no memory activity.
- ACCESS behaviour:
  - `mem_address` and `mem_data_in` come from the latched values.
  - Load: `mem_r_en=1` in every ACCESS cycle.
  - Store: `mem_w_en=1` only in the cycle where the counter is 0, giving exactly one write per store.
  - Counter decrements each cycle.
  - When the counter is 0: a load captures `mem_data_out` into `rdata`; go to DONE.
- DONE behaviour:
  - `ready=1`; `fault` equals the latched fault.
  - Request inputs are ignored, because the pipeline advances at the end of this cycle.
  - Next state is always IDLE.
- `freeze = !rst && ((IDLE && request) || ACCESS)`.
- `rdata` changes only on a successful load completion. Stores and faults leave it unchanged.
- `mem_*` outputs are 0 in IDLE and DONE.

## Timing
- Reset values: state IDLE; `freeze`, `ready`, `fault`, `mem_r_en` and `mem_w_en` all 0; `rdata`, `mem_address`, `mem_data_in` and the counter all 0.
- Valid request first seen in cycle T:
  - `freeze` is high from T through T+WAIT_CYCLES.
  - ACCESS occupies T+1 .. T+WAIT_CYCLES.
  - `ready` is high in T+WAIT_CYCLES+1.
  - `rdata` is valid from T+WAIT_CYCLES+1.
- Store: the memory write edge is the end of cycle T+WAIT_CYCLES.
- Faulted request: `freeze` high in T only; `ready=1` and `fault=1` in T+1.
- Back-to-back requests: a request held after DONE is accepted in the following IDLE cycle. The minimum period is WAIT_CYCLES+2 cycles.
- `rst` during ACCESS: return to IDLE next edge.
  - A store whose write cycle has not yet been reached is not issued.
  - No `ready` pulse.
  - `rdata` is cleared to 0.
- `rst` has priority over every transition.

## Test plan
- Load with WAIT_CYCLES=3: preload mem[1024]=0xDEADBEEF; req_r_en at 0x400 in T -> `freeze` high T..T+3, `mem_r_en` high T+1..T+3, `ready` high T+4, `rdata`=0xDEADBEEF, `fault`=0.
- Store then load: store 0x12345678 to 0x404 -> single `mem_w_en` pulse at T+3; subsequent load of 0x404 -> `rdata`=0x12345678; `rdata` unchanged during the store.
- Faults, each giving a 1-cycle `freeze`, then `ready=1`/`fault=1`, no `mem_*` activity, and `rdata` unchanged:
  - Address 0x402.
  - Address 0x3FC.
  - Address 0x2400.
  - Both enables high at 0x400.
- Boundary: load at 0x23FC (last word) -> accepted, `fault`=0.
- Request held continuously across two loads -> second acceptance in the IDLE cycle after DONE; period WAIT_CYCLES+2=5.
- `rst` asserted at T+1 of a store with WAIT_CYCLES=3 -> no `mem_w_en`, no `ready`, all outputs 0 next cycle, memory contents unchanged.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: multi-cycle MEM-stage data-memory access controller with fault rejection
// Ports: clk/rst; req_r_en, req_w_en, req_addr, req_wdata from EXE/MEM;
// freeze (comb stall), ready (done pulse), fault (reject, valid with ready), rdata (last load);
// mem_r_en, mem_w_en, mem_address, mem_data_in to memory; mem_data_out from memory.
module mem_access_ctrl #(
  parameter int WAIT_CYCLES = 3,
  parameter int BASE_ADDR = 1024,
  parameter int DEPTH_WORDS = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_r_en,
  input  logic        req_w_en,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        freeze,
  output logic        ready,
  output logic        fault,
  output logic [31:0] rdata,
  output logic        mem_r_en,
  output logic        mem_w_en,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  // 33-bit bounds so the upper limit cannot wrap past 2^32
  localparam logic [32:0] lo_addr = 33'(BASE_ADDR);
  localparam logic [32:0] hi_addr = 33'(BASE_ADDR) + (33'(DEPTH_WORDS) << 2);
  state_t state, nxt;
  logic [3:0] cnt;
  logic [31:0] addr, wdata;
  logic is_store, fault_q, req, addr_ok, accept, last;
  always_comb begin
    req = req_r_en | req_w_en;
    addr_ok = req_addr[1:0] == 2'b00 && {1'b0, req_addr} >= lo_addr && {1'b0, req_addr} < hi_addr;
    accept = addr_ok && (req_r_en ^ req_w_en);
    last = cnt == 4'd0;
    nxt = (state == IDLE) ? (!req ? IDLE : accept ? ACCESS : DONE) :
          (state == ACCESS && !last) ? ACCESS :
          (state == ACCESS) ? DONE : IDLE;
    freeze = !rst && ((state == IDLE && req) || state == ACCESS);
    ready = state == DONE;
    fault = ready && fault_q;
    mem_r_en = state == ACCESS && !is_store;
    mem_w_en = state == ACCESS && is_store && last;
    mem_address = (state == ACCESS) ? addr : '0;
    mem_data_in = (state == ACCESS) ? wdata : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      addr <= '0;
      wdata <= '0;
      is_store <= 1'b0;
      fault_q <= 1'b0;
      rdata <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && req) begin
        fault_q <= !accept;
        if (accept) begin
          addr <= req_addr;
          wdata <= req_wdata;
          is_store <= req_w_en;
          cnt <= 4'(WAIT_CYCLES - 1);
        end
      end
      if (state == ACCESS) begin
        if (!last) cnt <= cnt - 4'd1;
        else if (!is_store) rdata <= mem_data_out;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: table-driven and scoreboard bench for mem_access_ctrl
module tb_mem_access_ctrl;
  localparam int W = 3;
  logic clk = 0, rst = 1, req_r_en = 0, req_w_en = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic freeze, ready, fault, mem_r_en, mem_w_en;
  logic [31:0] rdata, mem_address, mem_data_in, mem_data_out;
  int checks = 0, passes = 0;
  logic [31:0] tbmem [0:2047];
  logic [31:0] off;
  logic [10:0] idx;
  assign off = mem_address - 32'd1024;
  assign idx = off[12:2];
  assign mem_data_out = tbmem[idx];
  always @(posedge clk) if (mem_w_en) tbmem[idx] <= mem_data_in;
  always #5 clk = ~clk;

  mem_access_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(1024), .DEPTH_WORDS(2048)) dut (
    .clk(clk), .rst(rst), .req_r_en(req_r_en), .req_w_en(req_w_en),
    .req_addr(req_addr), .req_wdata(req_wdata), .freeze(freeze), .ready(ready),
    .fault(fault), .rdata(rdata), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  typedef struct { logic r; logic w; logic [31:0] a; logic [31:0] d; logic f; logic [31:0] rd; } vec_t;
  typedef struct { logic f; logic [31:0] d; } exp_t;
  exp_t sbq[$];
  exp_t sb_e;
  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (ready) begin
      if (sbq.size() == 0) begin
        checks++;
        $display("FAIL sb_unexpected_ready: got ready=1 expected no completion");
      end else begin
        sb_e = sbq.pop_front();
        chk("sb_fault", 32'(fault), 32'(sb_e.f));
        chk("sb_rdata", rdata, sb_e.d);
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int lat, fz, rc, wc;
    logic stable, wok;
    logic [31:0] r0;
    exp_t e;
    @(negedge clk);
    req_r_en = v.r; req_w_en = v.w; req_addr = v.a; req_wdata = v.d;
    e.f = v.f; e.d = v.rd;
    sbq.push_back(e);
    r0 = rdata;
    #1;
    lat = -1; fz = 0; rc = 0; wc = 0; stable = 1; wok = 1;
    for (int n = 0; n < 20; n++) begin
      fz += int'(freeze);
      rc += int'(mem_r_en);
      if (mem_w_en) begin
        wc++;
        if (n != W || mem_address !== v.a || mem_data_in !== v.d) wok = 0;
      end
      if (ready) begin
        lat = n;
        break;
      end
      if (rdata !== r0) stable = 0;
      @(negedge clk);
      if (n == 0) begin
        req_r_en = 0; req_w_en = 0;
      end
      #1;
    end
    req_r_en = 0; req_w_en = 0;
    chk("latency", 32'(lat), v.f ? 32'd1 : 32'(W + 1));
    chk("freeze_cycles", 32'(fz), v.f ? 32'd1 : 32'(W + 1));
    chk("read_cycles", 32'(rc), (v.r && !v.f) ? 32'(W) : 32'd0);
    chk("write_pulses", 32'(wc), (v.w && !v.f) ? 32'd1 : 32'd0);
    chk("write_timing", 32'(wok), 32'd1);
    chk("rdata_stable", 32'(stable), 32'd1);
  endtask

  initial begin
    int first, second, wc, rdy;
    exp_t e;
    for (int i = 0; i < 2048; i++) tbmem[i] = '0;
    tbmem[0] = 32'hDEADBEEF;
    tbmem[2047] = 32'hCAFEF00D;
    vecs[0] = '{1'b1, 1'b0, 32'h400, 32'h0, 1'b0, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 1'b1, 32'h404, 32'h12345678, 1'b0, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b0, 32'h404, 32'h0, 1'b0, 32'h12345678};
    vecs[3] = '{1'b1, 1'b0, 32'h402, 32'h0, 1'b1, 32'h12345678};
    vecs[4] = '{1'b1, 1'b0, 32'h3FC, 32'h0, 1'b1, 32'h12345678};
    vecs[5] = '{1'b0, 1'b1, 32'h2400, 32'h1, 1'b1, 32'h12345678};
    vecs[6] = '{1'b1, 1'b1, 32'h400, 32'h2, 1'b1, 32'h12345678};
    vecs[7] = '{1'b1, 1'b0, 32'h23FC, 32'h0, 1'b0, 32'hCAFEF00D};
    vecs[8] = '{1'b0, 1'b1, 32'h23FC, 32'h0BADF00D, 1'b0, 32'hCAFEF00D};
    vecs[9] = '{1'b1, 1'b0, 32'h23FC, 32'h0, 1'b0, 32'h0BADF00D};
    repeat (2) @(negedge clk);
    chk("rst_freeze", 32'(freeze), 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_mem_r_en", 32'(mem_r_en), 0);
    chk("rst_mem_w_en", 32'(mem_w_en), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_data_in", mem_data_in, 0);
    rst = 0;
    for (int i = 0; i < 10; i++) run_vec(vecs[i]);
    if (tbmem[2047] !== 32'h0BADF00D || tbmem[1] !== 32'h12345678) chk("mem_contents", tbmem[2047], 32'h0BADF00D);
    else chk("mem_contents", tbmem[1], 32'h12345678);
    @(negedge clk);
    req_r_en = 1; req_addr = 32'h400;
    e.f = 0; e.d = 32'hDEADBEEF;
    sbq.push_back(e);
    sbq.push_back(e);
    #1;
    first = -1; second = -1;
    for (int n = 0; n < 16; n++) begin
      if (ready) begin
        if (first < 0) first = n;
        else begin
          second = n;
          req_r_en = 0;
          break;
        end
      end
      @(negedge clk);
      #1;
    end
    req_r_en = 0;
    chk("b2b_first_ready", 32'(first), 32'(W + 1));
    chk("b2b_second_ready", 32'(second), 32'(2 * W + 3));
    @(negedge clk);
    req_w_en = 1; req_addr = 32'h404; req_wdata = 32'h55555555;
    #1;
    wc = int'(mem_w_en);
    rdy = int'(ready);
    @(negedge clk);
    req_w_en = 0; rst = 1;
    #1;
    wc += int'(mem_w_en);
    rdy += int'(ready);
    @(negedge clk);
    #1;
    chk("rstacc_freeze", 32'(freeze), 0);
    chk("rstacc_ready", 32'(ready), 0);
    chk("rstacc_fault", 32'(fault), 0);
    chk("rstacc_mem_r_en", 32'(mem_r_en), 0);
    chk("rstacc_mem_w_en", 32'(mem_w_en), 0);
    chk("rstacc_mem_address", mem_address, 0);
    chk("rstacc_mem_data_in", mem_data_in, 0);
    chk("rstacc_rdata", rdata, 0);
    rst = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      #1;
      wc += int'(mem_w_en);
      rdy += int'(ready);
    end
    chk("rstacc_no_write", 32'(wc), 0);
    chk("rstacc_no_ready", 32'(rdy), 0);
    chk("rstacc_mem_kept", tbmem[1], 32'h12345678);
    chk("sb_empty", 32'(sbq.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
